alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter_pkg.sv | 23 ++
 rtl/alu_arbiter_alu.sv | 29 ++
 rtl/alu_arbiter.sv | 152 +++++++++++++++
 tb/tb_alu_arbiter.sv | 372 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared definitions for the ALU arbiter: opcode values, FSM state encoding
// and a small opcode classification helper.
package alu_arbiter_pkg;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_NOT = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    // Opcodes 110 and 111 have no ALU meaning and are reported as errors
    function automatic logic op_unsupported(input logic [2:0] op);
        return op[2] & op[1];
    endfunction

endpackage

// File: rtl/alu_arbiter_alu.sv
// Combinational single-operand ALU; the zero-extended operand is combined
// with the constant 1 according to the opcode.
module alu_arbiter_alu
    import alu_arbiter_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [7:0]  num1,
    output logic [31:0] s
);

    logic [31:0] a_s;

    assign a_s = {24'd0, num1};

    // Opcode decode; unsupported opcodes produce zero
    always_comb begin
        s = 32'd0;
        case (op)
            OP_ADD:  s = a_s + 32'd1;
            OP_SUB:  s = a_s - 32'd1;
            OP_AND:  s = a_s & 32'd1;
            OP_OR:   s = a_s | 32'd1;
            OP_NOT:  s = ~a_s;
            OP_SHL:  s = {a_s[30:0], 1'b1};
            default: s = 32'd0;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Round-robin arbiter sharing one ALU among NREQ requesters; one transaction
// in flight at a time, IDLE -> EXEC -> RESP, result held until consumed.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int NREQ = 2,
    parameter int IDW  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req_valid,
    input  logic [3*NREQ-1:0] req_op,
    input  logic [8*NREQ-1:0] req_num,
    output logic [NREQ-1:0]   req_ready,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_data,
    output logic [IDW-1:0]    rsp_id,
    output logic              rsp_err,
    output logic [15:0]       done_cnt
);

    state_t          state_r;
    logic [IDW-1:0]  last_grant_r;
    logic [IDW-1:0]  id_r;
    logic [2:0]      op_r;
    logic [7:0]      num_r;
    logic            rsp_valid_r;
    logic [31:0]     rsp_data_r;
    logic [IDW-1:0]  rsp_id_r;
    logic            rsp_err_r;
    logic [15:0]     done_cnt_r;

    logic            grant_found_s;
    logic [IDW-1:0]  grant_idx_s;
    logic [2:0]      gnt_op_s;
    logic [7:0]      gnt_num_s;
    logic [31:0]     alu_s;
    int              dist_s;
    int              best_dist_s;

    // Round-robin pick: valid requester closest after last_grant wins
    always_comb begin
        grant_found_s = 1'b0;
        grant_idx_s   = {IDW{1'b0}};
        best_dist_s   = NREQ;
        dist_s        = 0;
        for (int i = 0; i < NREQ; i++) begin
            dist_s = (i + NREQ - 1 - int'(last_grant_r)) % NREQ;
            if (req_valid[i] && (dist_s < best_dist_s)) begin
                best_dist_s   = dist_s;
                grant_idx_s   = IDW'(i);
                grant_found_s = 1'b1;
            end else begin
                best_dist_s   = best_dist_s;
            end
        end
    end

    // One-hot accept, only while idle and out of reset
    always_comb begin
        req_ready = {NREQ{1'b0}};
        if (!rst && (state_r == IDLE) && grant_found_s) begin
            for (int i = 0; i < NREQ; i++) begin
                if (grant_idx_s == IDW'(i)) begin
                    req_ready[i] = 1'b1;
                end else begin
                    req_ready[i] = 1'b0;
                end
            end
        end else begin
            req_ready = {NREQ{1'b0}};
        end
    end

    // Payload mux for the granted requester
    always_comb begin
        gnt_op_s  = 3'd0;
        gnt_num_s = 8'd0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_idx_s == IDW'(i)) begin
                gnt_op_s  = req_op[3*i +: 3];
                gnt_num_s = req_num[8*i +: 8];
            end else begin
                gnt_op_s  = gnt_op_s;
            end
        end
    end

    alu_arbiter_alu u_alu (
        .op   (op_r),
        .num1 (num_r),
        .s    (alu_s)
    );

    // Transaction FSM with registered response and completion counter
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            last_grant_r <= IDW'(NREQ - 1);
            id_r         <= {IDW{1'b0}};
            op_r         <= 3'd0;
            num_r        <= 8'd0;
            rsp_valid_r  <= 1'b0;
            rsp_data_r   <= 32'd0;
            rsp_id_r     <= {IDW{1'b0}};
            rsp_err_r    <= 1'b0;
            done_cnt_r   <= 16'd0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (grant_found_s) begin
                        op_r         <= gnt_op_s;
                        num_r        <= gnt_num_s;
                        id_r         <= grant_idx_s;
                        last_grant_r <= grant_idx_s;
                        state_r      <= EXEC;
                    end else begin
                        state_r      <= IDLE;
                    end
                end
                EXEC: begin
                    rsp_data_r  <= op_unsupported(op_r) ? 32'd0 : alu_s;
                    rsp_err_r   <= op_unsupported(op_r);
                    rsp_id_r    <= id_r;
                    rsp_valid_r <= 1'b1;
                    state_r     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_r <= 1'b0;
                        done_cnt_r  <= done_cnt_r + 16'd1;
                        state_r     <= IDLE;
                    end else begin
                        state_r     <= RESP;
                    end
                end
                default: begin
                    rsp_valid_r <= 1'b0;
                    state_r     <= IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = rsp_valid_r;
    assign rsp_data  = rsp_data_r;
    assign rsp_id    = rsp_id_r;
    assign rsp_err   = rsp_err_r;
    assign done_cnt  = done_cnt_r;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized
// transactions compared against an arithmetic reference model.
module tb_alu_arbiter;

    localparam int NREQ = 2;
    localparam int IDW  = 2;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req_valid;
    logic [3*NREQ-1:0] req_op;
    logic [8*NREQ-1:0] req_num;
    logic [NREQ-1:0]   req_ready;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_data;
    logic [IDW-1:0]    rsp_id;
    logic              rsp_err;
    logic [15:0]       done_cnt;

    logic [2:0] op_a  [NREQ];
    logic [7:0] num_a [NREQ];
    int vectors     = 0;
    int miscompares = 0;
    int m_last;
    int m_done;

    assign req_op  = {op_a[1], op_a[0]};
    assign req_num = {num_a[1], num_a[0]};

    always #5 clk = ~clk;

    alu_arbiter #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_op    (req_op),
        .req_num   (req_num),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id),
        .rsp_err   (rsp_err),
        .done_cnt  (done_cnt)
    );

    function automatic logic [31:0] alu_ref(input logic [2:0] op, input logic [7:0] n);
        longint v;
        v = longint'(n);
        case (op)
            3'd0:    return 32'(v + 1);
            3'd1:    return 32'(v - 1);
            3'd2:    return 32'(v % 2);
            3'd3:    return 32'(v + ((v % 2 == 0) ? 1 : 0));
            3'd4:    return 32'(64'hFFFF_FFFF - v);
            3'd5:    return 32'(v * 2 + 1);
            default: return 32'd0;
        endcase
    endfunction

    function automatic int rr_pick(input int last, input logic [NREQ-1:0] mask);
        int idx;
        for (int k = 1; k <= NREQ; k++) begin
            idx = (last + k) % NREQ;
            if (mask[1'(idx)]) return idx;
        end
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst = 1'b1; req_valid = 2'b00; rsp_ready = 1'b0;
        tick();
        rst = 1'b0;
        m_last = NREQ - 1; m_done = 0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 2'b11; rsp_ready = 1'b1;
        op_a[0] = 3'd0; op_a[1] = 3'd0; num_a[0] = 8'h01; num_a[1] = 8'h02;
        tick(); tick();
        vectors++;
        if (req_ready !== 2'b00) begin
            miscompares++; $display("FAIL reset_req_ready: got %b expected 00", req_ready);
        end
        vectors++;
        if ({rsp_valid, rsp_id, rsp_err, rsp_data, done_cnt} !== {1'b0, 2'b00, 1'b0, 32'h0, 16'h0}) begin
            miscompares++;
            $display("FAIL reset_outputs: got v=%b id=%0d e=%b d=%h cnt=%h expected all zero",
                     rsp_valid, rsp_id, rsp_err, rsp_data, done_cnt);
        end
        apply_reset();
    endtask

    task automatic test_single();
        req_valid = 2'b01; op_a[0] = 3'b000; num_a[0] = 8'h7F; rsp_ready = 1'b0;
        #1;
        vectors++;
        if (req_ready !== 2'b01) begin
            miscompares++; $display("FAIL single_grant: got %b expected 01", req_ready);
        end
        tick();
        req_valid = 2'b00; num_a[0] = 8'hFF; op_a[0] = 3'b111;
        #1;
        vectors++;
        if ({rsp_valid, req_ready} !== 3'b000) begin
            miscompares++; $display("FAIL single_exec: got v=%b rdy=%b expected 0 00", rsp_valid, req_ready);
        end
        tick();
        vectors++;
        if ({rsp_valid, rsp_id, rsp_err, rsp_data} !== {1'b1, 2'd0, 1'b0, 32'h0000_0080}) begin
            miscompares++;
            $display("FAIL single_rsp: got v=%b id=%0d e=%b d=%h expected 1 0 0 00000080",
                     rsp_valid, rsp_id, rsp_err, rsp_data);
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0;
        m_done = m_done + 1; m_last = 0;
        vectors++;
        if ({rsp_valid, done_cnt} !== {1'b0, 16'(m_done)}) begin
            miscompares++; $display("FAIL single_done: got v=%b cnt=%h expected 0 %h", rsp_valid, done_cnt, 16'(m_done));
        end
    endtask

    task automatic test_round_robin();
        int g;
        apply_reset();
        op_a[0] = 3'b000; op_a[1] = 3'b011;
        num_a[0] = 8'($urandom); num_a[1] = 8'($urandom);
        req_valid = 2'b11; rsp_ready = 1'b1;
        for (int t = 0; t < 4; t++) begin
            #1;
            g = rr_pick(m_last, 2'b11);
            vectors++;
            if (req_ready !== (2'b01 << g)) begin
                miscompares++; $display("FAIL rr_grant[%0d]: got %b expected %b", t, req_ready, 2'b01 << g);
            end
            tick(); tick();
            vectors++;
            if ({rsp_valid, rsp_id, rsp_data} !== {1'b1, 2'(g), alu_ref(op_a[1'(g)], num_a[1'(g)])}) begin
                miscompares++;
                $display("FAIL rr_rsp[%0d]: got v=%b id=%0d d=%h expected 1 %0d %h", t, rsp_valid, rsp_id,
                         rsp_data, g, alu_ref(op_a[1'(g)], num_a[1'(g)]));
            end
            tick();
            m_last = g; m_done = m_done + 1;
        end
        rsp_ready = 1'b0; req_valid = 2'b00;
        vectors++;
        if (done_cnt !== 16'(m_done)) begin
            miscompares++; $display("FAIL rr_done: got %h expected %h", done_cnt, 16'(m_done));
        end
    endtask

    task automatic test_backpressure();
        int g;
        req_valid = 2'b10; op_a[1] = 3'b100; num_a[1] = 8'h00; rsp_ready = 1'b0;
        #1;
        g = rr_pick(m_last, 2'b10);
        vectors++;
        if (req_ready !== (2'b01 << g)) begin
            miscompares++; $display("FAIL bp_grant: got %b expected %b", req_ready, 2'b01 << g);
        end
        tick();
        req_valid = 2'b11;
        tick();
        for (int h = 0; h <= 5; h++) begin
            vectors++;
            if ({rsp_valid, rsp_id, rsp_err, rsp_data} !== {1'b1, 2'(g), 1'b0, 32'hFFFF_FFFF}) begin
                miscompares++;
                $display("FAIL bp_hold[%0d]: got v=%b id=%0d e=%b d=%h expected 1 %0d 0 ffffffff",
                         h, rsp_valid, rsp_id, rsp_err, rsp_data, g);
            end
            if (h < 5) begin
                req_valid = 2'($urandom_range(1, 3));
                #1;
                vectors++;
                if (req_ready !== 2'b00) begin
                    miscompares++; $display("FAIL bp_ready[%0d]: got %b expected 00", h, req_ready);
                end
                tick();
            end
        end
        rsp_ready = 1'b1;
        tick();
        rsp_ready = 1'b0; req_valid = 2'b00;
        m_done = m_done + 1; m_last = g;
        vectors++;
        if ({rsp_valid, done_cnt} !== {1'b0, 16'(m_done)}) begin
            miscompares++; $display("FAIL bp_done: got v=%b cnt=%h expected 0 %h", rsp_valid, done_cnt, 16'(m_done));
        end
    endtask

    task automatic test_err_boundary();
        logic [2:0]  t_op  [2];
        logic [7:0]  t_num [2];
        logic [31:0] t_d   [2];
        logic        t_e   [2];
        int g;
        t_op[0] = 3'b110; t_num[0] = 8'h55; t_d[0] = 32'h0000_0000; t_e[0] = 1'b1;
        t_op[1] = 3'b001; t_num[1] = 8'h00; t_d[1] = 32'hFFFF_FFFF; t_e[1] = 1'b0;
        for (int e = 0; e < 2; e++) begin
            op_a[0] = t_op[e]; op_a[1] = t_op[e]; num_a[0] = t_num[e]; num_a[1] = t_num[e];
            req_valid = 2'b11;
            #1;
            g = rr_pick(m_last, 2'b11);
            tick();
            req_valid = 2'b00;
            tick();
            vectors++;
            if ({rsp_valid, rsp_id, rsp_err, rsp_data} !== {1'b1, 2'(g), t_e[e], t_d[e]}) begin
                miscompares++;
                $display("FAIL err_case[%0d]: got v=%b id=%0d e=%b d=%h expected 1 %0d %b %h",
                         e, rsp_valid, rsp_id, rsp_err, rsp_data, g, t_e[e], t_d[e]);
            end
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
            m_last = g; m_done = m_done + 1;
        end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        op_a[0] = 3'b000; num_a[0] = 8'h10; op_a[1] = 3'b000; num_a[1] = 8'h20;
        req_valid = 2'b01;
        tick();
        req_valid = 2'b00; rst = 1'b1;
        tick();
        rst = 1'b0; req_valid = 2'b11;
        #1;
        vectors++;
        if ({rsp_valid, done_cnt, req_ready} !== {1'b0, 16'h0, 2'b01}) begin
            miscompares++;
            $display("FAIL rst_exec: got v=%b cnt=%h rdy=%b expected 0 0000 01", rsp_valid, done_cnt, req_ready);
        end
        tick();
        req_valid = 2'b00;
        tick();
        rsp_ready = 1'b1; rst = 1'b1;
        tick();
        rst = 1'b0; rsp_ready = 1'b0; req_valid = 2'b11;
        #1;
        vectors++;
        if ({rsp_valid, done_cnt, req_ready} !== {1'b0, 16'h0, 2'b01}) begin
            miscompares++;
            $display("FAIL rst_resp: got v=%b cnt=%h rdy=%b expected 0 0000 01", rsp_valid, done_cnt, req_ready);
        end
        req_valid = 2'b00;
        m_last = NREQ - 1; m_done = 0;
    endtask

    task automatic test_random();
        logic [1:0]  mask;
        logic [31:0] exp_d;
        logic        exp_e;
        int g;
        int hold;
        for (int it = 0; it < 40; it++) begin
            mask = 2'($urandom_range(0, 3));
            for (int i = 0; i < NREQ; i++) begin
                op_a[i] = 3'($urandom_range(0, 7)); num_a[i] = 8'($urandom);
            end
            req_valid = mask; rsp_ready = 1'($urandom);
            #1;
            g = rr_pick(m_last, mask);
            vectors++;
            if (g < 0) begin
                if (req_ready !== 2'b00) begin
                    miscompares++; $display("FAIL rand_idle[%0d]: got %b expected 00", it, req_ready);
                end
                tick();
            end else begin
                if (req_ready !== (2'b01 << g)) begin
                    miscompares++; $display("FAIL rand_grant[%0d]: got %b expected %b", it, req_ready, 2'b01 << g);
                end
                exp_d = alu_ref(op_a[1'(g)], num_a[1'(g)]);
                exp_e = (op_a[1'(g)] >= 3'd6);
                hold  = $urandom_range(0, 3);
                tick();
                req_valid = 2'($urandom); rsp_ready = 1'($urandom);
                for (int i = 0; i < NREQ; i++) begin
                    op_a[i] = 3'($urandom); num_a[i] = 8'($urandom);
                end
                #1;
                vectors++;
                if ({rsp_valid, req_ready} !== 3'b000) begin
                    miscompares++; $display("FAIL rand_exec[%0d]: got v=%b rdy=%b expected 0 00", it, rsp_valid, req_ready);
                end
                rsp_ready = 1'b0;
                tick();
                for (int h = 0; h <= hold; h++) begin
                    vectors++;
                    if ({rsp_valid, rsp_id, rsp_err, rsp_data, req_ready} !== {1'b1, 2'(g), exp_e, exp_d, 2'b00}) begin
                        miscompares++;
                        $display("FAIL rand_rsp[%0d.%0d]: got v=%b id=%0d e=%b d=%h rdy=%b expected 1 %0d %b %h 00",
                                 it, h, rsp_valid, rsp_id, rsp_err, rsp_data, req_ready, g, exp_e, exp_d);
                    end
                    if (h < hold) begin
                        req_valid = 2'($urandom);
                        tick();
                    end
                end
                rsp_ready = 1'b1;
                tick();
                rsp_ready = 1'b0;
                m_done = m_done + 1; m_last = g;
                vectors++;
                if (rsp_valid !== 1'b0) begin
                    miscompares++; $display("FAIL rand_drop[%0d]: got %b expected 0", it, rsp_valid);
                end
            end
            vectors++;
            if (done_cnt !== 16'(m_done)) begin
                miscompares++; $display("FAIL rand_done[%0d]: got %h expected %h", it, done_cnt, 16'(m_done));
            end
        end
        req_valid = 2'b00; rsp_ready = 1'b0;
    endtask

    task automatic test_wrap();
        int g;
        req_valid = 2'b00; rsp_ready = 1'b0;
        force dut.done_cnt_r = 16'hFFFE;
        #1;
        release dut.done_cnt_r;
        m_done = 32'hFFFE;
        for (int t = 0; t < 2; t++) begin
            op_a[0] = 3'd0; num_a[0] = 8'($urandom); op_a[1] = 3'd0; num_a[1] = 8'($urandom);
            req_valid = 2'b11;
            #1;
            g = rr_pick(m_last, 2'b11);
            tick();
            req_valid = 2'b00;
            tick();
            rsp_ready = 1'b1;
            tick();
            rsp_ready = 1'b0;
            m_done = (m_done + 1) % 65536; m_last = g;
            vectors++;
            if (done_cnt !== 16'(m_done)) begin
                miscompares++; $display("FAIL wrap[%0d]: got %h expected %h", t, done_cnt, 16'(m_done));
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected normal completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_err_boundary();
        test_reset_mid();
        test_random();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
